// File: rtl/scan_mux_if.sv
// scan_mux_if: source-side inputs and registered selection outputs of scan_mux
interface scan_mux_if #(
  parameter int N_CH    = 8,
  parameter int W       = 8,
  parameter int SEL_W   = $clog2(N_CH),
  parameter int DWELL_W = 8
);
  logic [N_CH*W-1:0]  I;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   S;
  logic [DWELL_W-1:0] dwell;
  logic [N_CH-1:0]    ch_mask;
  logic [W-1:0]       Y;
  logic [SEL_W-1:0]   ch;
  logic               valid;
  logic               wrap;
  modport master (output I, en, mode, S, dwell, ch_mask, input Y, ch, valid, wrap);
  modport slave  (input I, en, mode, S, dwell, ch_mask, output Y, ch, valid, wrap);
endinterface

// File: rtl/scan_mux.sv
// scan_mux: N-channel registered mux with manual select and masked auto-scan with dwell
module scan_mux #(
  parameter int N_CH    = 8,
  parameter int W       = 8,
  parameter int SEL_W   = $clog2(N_CH),
  parameter int DWELL_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  scan_mux_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;
  state_t             state, state_n;
  logic [W-1:0]       y_q, y_n;
  logic [SEL_W-1:0]   ch_q, ch_n, ptr, ptr_n, low, nxt;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               valid_q, valid_n, wrap_q, wrap_n;
  logic               empty, empty_n;
  assign bus.Y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  // lowest set mask bit (restart point) and next set bit cyclically above ptr
  always_comb begin
    low = '0;
    nxt = ptr;
    for (int k = N_CH - 1; k >= 0; k--)
      if (bus.ch_mask[k]) low = SEL_W'(k);
    for (int k = N_CH - 1; k >= 1; k--)
      if (bus.ch_mask[(int'(ptr) + k) % N_CH]) nxt = SEL_W'((int'(ptr) + k) % N_CH);
  end
  // next state from en/mode; the target state's rule decides every register update
  always_comb begin
    state_n = !bus.en ? IDLE : bus.mode ? SCAN : MAN;
    y_n     = y_q;
    ch_n    = ch_q;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    ptr_n   = ptr;
    cnt_n   = '0;
    empty_n = empty;
    if (state_n == MAN) begin
      valid_n = int'(bus.S) < N_CH;
      y_n     = valid_n ? bus.I[bus.S*W +: W] : '0;
      ch_n    = bus.S;
    end else if (state_n == SCAN) begin
      if (bus.ch_mask == '0) begin
        empty_n = 1'b1;
      end else if (state != SCAN || empty) begin
        ptr_n   = low;
        empty_n = 1'b0;
      end else begin
        y_n     = bus.I[ptr*W +: W];
        ch_n    = ptr;
        valid_n = 1'b1;
        if (cnt >= bus.dwell) begin
          ptr_n  = nxt;
          wrap_n = nxt <= ptr;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      empty   <= 1'b0;
    end else begin
      state   <= state_n;
      y_q     <= y_n;
      ch_q    <= ch_n;
      valid_q <= valid_n;
      wrap_q  <= wrap_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      empty   <= empty_n;
    end
  end
endmodule
